weight_ram_sequencer: RTL

Controller in front of the 165-entry × 10-bit signed weight RAM of the 30-5-3 network. It fills the RAM with pseudo-random initial weights and translates (layer, row, col) weight coordinates into RAM addresses. It arbitrates between a forward-pass read port and a training update port; updates are read-modify-write with saturating delta add. It is the only master of the RAM address, data and write-enable lines.

---
 rtl/weight_pkg.sv | 61 ++++++
 rtl/weight_lfsr.sv | 27 ++
 rtl/weight_ram_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/weight_pkg.sv
// Shared constants, FSM state encoding and weight arithmetic helpers
// for the 30-5-3 network weight RAM sequencer.
package weight_pkg;

    localparam int N_IN         = 30;
    localparam int N_HID        = 5;
    localparam int N_OUT        = 3;
    localparam int WEIGHT_W     = 10;
    localparam int ADDR_W       = 8;
    localparam int N_WEIGHTS    = 165;
    localparam int HID_OUT_BASE = 150;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ARB,
        RD_ADDR,
        RD_CAP,
        UPD_ADDR,
        UPD_CAP,
        UPD_WR
    } state_t;

    // Signed add at 11 bits, clamped to the 10-bit range.
    function automatic logic [WEIGHT_W-1:0] sat10(
        input logic [WEIGHT_W-1:0] a,
        input logic [WEIGHT_W-1:0] b
    );
        logic signed [WEIGHT_W:0] s;
        s = $signed({a[WEIGHT_W-1], a}) + $signed({b[WEIGHT_W-1], b});
        if (s > 11'sd511) begin
            return 10'h1FF;
        end else if (s < -11'sd512) begin
            return 10'h200;
        end
        return s[WEIGHT_W-1:0];
    endfunction

    function automatic logic coord_ok(
        input logic       layer,
        input logic [2:0] row,
        input logic [4:0] col
    );
        if (layer) begin
            return (32'(row) < N_OUT) && (32'(col) < N_HID);
        end
        return (32'(row) < N_HID) && (32'(col) < N_IN);
    endfunction

    function automatic logic [ADDR_W-1:0] coord_addr(
        input logic       layer,
        input logic [2:0] row,
        input logic [4:0] col
    );
        if (layer) begin
            return 8'(HID_OUT_BASE) + 8'(row) * 8'(N_HID) + 8'(col);
        end
        return 8'(row) * 8'(N_IN) + 8'(col);
    endfunction

endpackage

// File: rtl/weight_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to seed initial weights.
// load restores the seed, step advances one position.
module weight_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clock,
    input  logic       load,
    input  logic       step,
    output logic [9:0] word
);

    logic [15:0] value;
    logic        fb;

    assign fb   = value[0] ^ value[2] ^ value[3] ^ value[5];
    assign word = value[9:0];

    // Seed on load, otherwise shift right with feedback into the MSB.
    always_ff @(posedge clock) begin
        if (load) begin
            value <= SEED;
        end else if (step) begin
            value <= {fb, value[15:1]};
        end
    end

endmodule

// File: rtl/weight_ram_sequencer.sv
// Weight RAM controller: random init, read port, saturating update port.
// Define ARB_RR_EN for round-robin arbitration (default: update first).
module weight_ram_sequencer
    import weight_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          INIT_SHIFT = 3
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       init_start,
    output logic       init_busy,
    output logic       init_done,
    input  logic       rd_req,
    input  logic       rd_layer,
    input  logic [2:0] rd_row,
    input  logic [4:0] rd_col,
    output logic       rd_ack,
    output logic [9:0] rd_data,
    output logic       rd_err,
    input  logic       upd_req,
    input  logic       upd_layer,
    input  logic [2:0] upd_row,
    input  logic [4:0] upd_col,
    input  logic [9:0] upd_delta,
    output logic       upd_ack,
    output logic       upd_err,
    output logic [7:0] ram_addr,
    output logic [9:0] ram_d,
    output logic       ram_we,
    input  logic [9:0] ram_q
);

    state_t      state;
    state_t      nxt;
    logic [7:0]  cnt;
    logic        done_q;
    logic        rd_ack_q;
    logic        rd_err_q;
    logic        upd_eack_q;
    logic [9:0]  rd_data_q;
    logic [7:0]  op_addr;
    logic [9:0]  op_delta;
    logic [9:0]  cap_q;
    logic [9:0]  lfsr_word;
    logic signed [9:0] lfsr_s;
    logic [9:0]  init_word;
    logic        rd_legal;
    logic        upd_legal;
    logic [7:0]  rd_addr_c;
    logic [7:0]  upd_addr_c;
    logic        rd_ok;
    logic        upd_ok;
    logic        pick_upd;
    logic        pick_rd;
    logic        init_last;

`ifdef ARB_RR_EN
    logic        last_upd;
`endif

    weight_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clock (clock),
        .load  (rst),
        .step  (state == INIT),
        .word  (lfsr_word)
    );

    assign lfsr_s     = lfsr_word;
    assign init_word  = lfsr_s >>> INIT_SHIFT;
    assign init_last  = (cnt == 8'(N_WEIGHTS - 1));

    assign rd_legal   = coord_ok(rd_layer, rd_row, rd_col);
    assign upd_legal  = coord_ok(upd_layer, upd_row, upd_col);
    assign rd_addr_c  = coord_addr(rd_layer, rd_row, rd_col);
    assign upd_addr_c = coord_addr(upd_layer, upd_row, upd_col);

    // A port whose ack is showing this cycle is not re-granted yet.
    assign rd_ok  = rd_req & ~rd_ack_q;
    assign upd_ok = upd_req & ~upd_eack_q;

`ifdef ARB_RR_EN
    assign pick_upd = upd_ok & (~rd_ok | ~last_upd);
`else
    assign pick_upd = upd_ok;
`endif
    assign pick_rd  = rd_ok & ~pick_upd;

    assign init_busy = (state == INIT);
    assign init_done = done_q;
    assign rd_ack    = rd_ack_q;
    assign rd_err    = rd_err_q;
    assign rd_data   = rd_data_q;
    assign upd_ack   = (state == UPD_WR) | upd_eack_q;
    assign upd_err   = upd_eack_q;

    // State register plus the datapath registers each state loads.
    always_ff @(posedge clock) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            done_q     <= 1'b0;
            rd_ack_q   <= 1'b0;
            rd_err_q   <= 1'b0;
            upd_eack_q <= 1'b0;
            rd_data_q  <= '0;
            op_addr    <= '0;
            op_delta   <= '0;
            cap_q      <= '0;
`ifdef ARB_RR_EN
            last_upd   <= 1'b0;
`endif
        end else begin
            state      <= nxt;
            rd_ack_q   <= 1'b0;
            rd_err_q   <= 1'b0;
            upd_eack_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (init_start) begin
                        cnt <= '0;
                    end
                end
                INIT: begin
                    cnt <= cnt + 8'd1;
                    if (init_last) begin
                        done_q <= 1'b1;
                    end
                end
                ARB: begin
                    if (init_start) begin
                        cnt    <= '0;
                        done_q <= 1'b0;
                    end else if (pick_upd) begin
                        op_addr    <= upd_addr_c;
                        op_delta   <= upd_delta;
                        upd_eack_q <= ~upd_legal;
`ifdef ARB_RR_EN
                        last_upd   <= 1'b1;
`endif
                    end else if (pick_rd) begin
                        op_addr  <= rd_addr_c;
                        rd_ack_q <= ~rd_legal;
                        rd_err_q <= ~rd_legal;
`ifdef ARB_RR_EN
                        last_upd <= 1'b0;
`endif
                    end
                end
                RD_ADDR: begin
                end
                RD_CAP: begin
                    rd_data_q <= ram_q;
                    rd_ack_q  <= 1'b1;
                end
                UPD_ADDR: begin
                end
                UPD_CAP: begin
                    cap_q <= ram_q;
                end
                UPD_WR: begin
                end
            endcase
        end
    end

    // Next state and RAM port drive.
    always_comb begin
        nxt      = state;
        ram_addr = '0;
        ram_d    = '0;
        ram_we   = 1'b0;
        unique case (state)
            IDLE: begin
                if (init_start) begin
                    nxt = INIT;
                end
            end
            INIT: begin
                ram_we   = 1'b1;
                ram_addr = cnt;
                ram_d    = init_word;
                if (init_last) begin
                    nxt = ARB;
                end
            end
            ARB: begin
                if (init_start) begin
                    nxt = INIT;
                end else if (pick_upd) begin
                    nxt = upd_legal ? UPD_ADDR : ARB;
                end else if (pick_rd) begin
                    nxt = rd_legal ? RD_ADDR : ARB;
                end
            end
            RD_ADDR: begin
                ram_addr = op_addr;
                nxt      = RD_CAP;
            end
            RD_CAP: begin
                nxt = ARB;
            end
            UPD_ADDR: begin
                ram_addr = op_addr;
                nxt      = UPD_CAP;
            end
            UPD_CAP: begin
                nxt = UPD_WR;
            end
            UPD_WR: begin
                ram_addr = op_addr;
                ram_d    = sat10(cap_q, op_delta);
                ram_we   = 1'b1;
                nxt      = ARB;
            end
        endcase
    end

endmodule
